// File: rtl/bcd_window_scroller.sv
// Purpose : selects a WIN_DIGITS-wide window of an N-digit BCD value; two debounced
//           push-buttons scroll the window one digit per press, saturating or wrapping.
// Latency : raw button high from sample edge k -> offset moves at edge k+1+DEBOUNCE_CYCLES;
//           window and limit flags are combinational from bcd and the registered offset.
// Backpressure: none; a held button yields one event, and simultaneous events cancel.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   bcd                  NUM_DIGITS packed BCD digits, digit 0 in [3:0]
//   btn_left/btn_right   raw async buttons (left = toward more significant digits)
//   wrap_en              1 = wrap at the ends, 0 = saturate
//   window               digits offset .. offset+WIN_DIGITS-1
//   offset               registered window offset
//   at_left_limit        offset == NUM_DIGITS-WIN_DIGITS
//   at_right_limit       offset == 0
module bcd_window_scroller #(
  parameter int NUM_DIGITS      = 5,
  parameter int WIN_DIGITS      = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  localparam int MAX_OFS = NUM_DIGITS - WIN_DIGITS,
  localparam int OFS_W   = (MAX_OFS > 0) ? $clog2(MAX_OFS + 1) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd,
  input  logic                    btn_left,
  input  logic                    btn_right,
  input  logic                    wrap_en,
  output logic [4*WIN_DIGITS-1:0] window,
  output logic [OFS_W-1:0]        offset,
  output logic                    at_left_limit,
  output logic                    at_right_limit
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int IDX_W = $clog2(4 * NUM_DIGITS) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [OFS_W-1:0] MAX_O    = OFS_W'(MAX_OFS);

  // Index 0 = left button, index 1 = right button.
  logic [1:0]       raw;
  logic [1:0]       s1;
  logic [1:0]       s2;
  logic [1:0]       deb;
  logic [CNT_W-1:0] cnt [2];
  logic [1:0]       rise;
  logic [IDX_W-1:0] idx;

  assign raw = {btn_right, btn_left};

  // A press is the edge on which the debounced level is about to flip 0 -> 1,
  // so the offset update lands on the same edge as the deb change.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rise[i] = !deb[i] && s2[i] && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= '0;
      s2  <= '0;
      deb <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == deb[i]) begin
          // Any return to the accepted level restarts the stability count.
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset <= '0;
    end else if (MAX_OFS > 0) begin
      if (rise[0] && !rise[1]) begin
        if (offset == MAX_O) begin
          offset <= wrap_en ? '0 : MAX_O;
        end else begin
          offset <= offset + OFS_W'(1);
        end
      end else if (rise[1] && !rise[0]) begin
        if (offset == '0) begin
          offset <= wrap_en ? MAX_O : '0;
        end else begin
          offset <= offset - OFS_W'(1);
        end
      end
    end
  end

  // Digit offset scaled to a bit index (4 bits per digit).
  assign idx            = IDX_W'({offset, 2'b00});
  assign window         = bcd[idx +: 4*WIN_DIGITS];
  assign at_left_limit  = (offset == MAX_O);
  assign at_right_limit = (offset == '0);

endmodule

// File: tb/tb_bcd_window_scroller.sv
module tb_bcd_window_scroller;

  localparam int D    = 16;
  localparam int MAXV = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] bcd;
  logic [15:0] bcd2;
  logic        btn_left, btn_right, wrap_en;
  logic [11:0] window;
  logic [1:0]  offset;
  logic        at_left_limit, at_right_limit;
  logic [15:0] window2;
  logic [0:0]  offset2;
  logic        at_left_limit2, at_right_limit2;

  always #5 clk = ~clk;

  bcd_window_scroller #(.NUM_DIGITS(5), .WIN_DIGITS(3), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .bcd(bcd), .btn_left(btn_left), .btn_right(btn_right),
    .wrap_en(wrap_en), .window(window), .offset(offset),
    .at_left_limit(at_left_limit), .at_right_limit(at_right_limit)
  );

  bcd_window_scroller #(.NUM_DIGITS(4), .WIN_DIGITS(4), .DEBOUNCE_CYCLES(D)) dut2 (
    .clk(clk), .rst_n(rst_n), .bcd(bcd2), .btn_left(btn_left), .btn_right(btn_right),
    .wrap_en(wrap_en), .window(window2), .offset(offset2),
    .at_left_limit(at_left_limit2), .at_right_limit(at_right_limit2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a button level is accepted once the synchronised input
  // (raw delayed two samples) has shown the opposite level for D samples in a row.
  int hist_l[$];
  int hist_r[$];
  int m_deb_l, m_deb_r, m_ofs;
  bit cmp_each = 1'b0;

  typedef struct {
    bit          l;
    bit          r;
    bit          wrap;
    int          exp_ofs;
    logic [11:0] exp_win;
    bit          exp_ll;
    bit          exp_rl;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    hist_l.delete();
    hist_r.delete();
    for (int i = 0; i < D + 2; i++) begin
      hist_l.push_back(0);
      hist_r.push_back(0);
    end
    m_deb_l = 0;
    m_deb_r = 0;
    m_ofs   = 0;
  endtask

  function automatic int flips(input int h[$], input int deb);
    for (int k = 2; k <= D + 1; k++) begin
      if (h[k] == deb) return 0;
    end
    return 1;
  endfunction

  task automatic compare_all(input string tag);
    logic [19:0] sh;
    sh = bcd >> (4 * m_ofs);
    check({tag, "_window"}, 32'(window), 32'(sh & 20'hFFF));
    check({tag, "_offset"}, 32'(offset), 32'(m_ofs));
    check({tag, "_left_limit"}, 32'(at_left_limit), 32'(m_ofs == MAXV));
    check({tag, "_right_limit"}, 32'(at_right_limit), 32'(m_ofs == 0));
    check({tag, "_full_window"}, 32'(window2), 32'(bcd2));
    check({tag, "_full_offset"}, 32'(offset2), 32'd0);
    check({tag, "_full_limits"}, {30'd0, at_left_limit2, at_right_limit2}, 32'd3);
  endtask

  task automatic tick();
    int nl, nr;
    bit el, er;
    if (rst_n) begin
      hist_l.push_front(int'(btn_left));
      void'(hist_l.pop_back());
      hist_r.push_front(int'(btn_right));
      void'(hist_r.pop_back());
      nl = flips(hist_l, m_deb_l) ? 1 - m_deb_l : m_deb_l;
      nr = flips(hist_r, m_deb_r) ? 1 - m_deb_r : m_deb_r;
      el = (nl == 1) && (m_deb_l == 0);
      er = (nr == 1) && (m_deb_r == 0);
      m_deb_l = nl;
      m_deb_r = nr;
      if (el && !er) m_ofs = (m_ofs == MAXV) ? (wrap_en ? 0 : MAXV) : m_ofs + 1;
      else if (er && !el) m_ofs = (m_ofs == 0) ? (wrap_en ? MAXV : 0) : m_ofs - 1;
    end
    @(posedge clk);
    #1;
    if (cmp_each) compare_all("rnd");
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input bit l, input bit r);
    btn_left  = l;
    btn_right = r;
    hold(20);
    btn_left  = 1'b0;
    btn_right = 1'b0;
    hold(20);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1, 12'h234, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 2, 12'h123, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 2, 12'h123, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 0, 12'h345, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 2, 12'h123, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1, 12'h234, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 0, 12'h345, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 0, 12'h345, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 0, 12'h345, 1'b0, 1'b1};

    rst_n     = 1'b0;
    bcd       = 20'h12345;
    bcd2      = 16'h9876;
    btn_left  = 1'b0;
    btn_right = 1'b0;
    wrap_en   = 1'b0;
    model_reset();
    hold(3);
    rst_n = 1'b1;
    hold(2);

    // Reset state
    check("reset_window", 32'(window), 32'h345);
    check("reset_offset", 32'(offset), 32'd0);
    check("reset_right_limit", 32'(at_right_limit), 32'd1);
    check("reset_left_limit", 32'(at_left_limit), 32'd0);
    check("reset_full_window", 32'(window2), 32'h9876);
    check("reset_full_limits", {30'd0, at_left_limit2, at_right_limit2}, 32'd3);

    // Press table: saturate, wrap and simultaneous presses
    for (int i = 0; i < 9; i++) begin
      wrap_en = tbl[i].wrap;
      press(tbl[i].l, tbl[i].r);
      check($sformatf("tbl%0d_offset", i), 32'(offset), 32'(tbl[i].exp_ofs));
      check($sformatf("tbl%0d_window", i), 32'(window), 32'(tbl[i].exp_win));
      check($sformatf("tbl%0d_left_limit", i), 32'(at_left_limit), 32'(tbl[i].exp_ll));
      check($sformatf("tbl%0d_right_limit", i), 32'(at_right_limit), 32'(tbl[i].exp_rl));
      check($sformatf("tbl%0d_full_window", i), 32'(window2), 32'h9876);
      check($sformatf("tbl%0d_full_offset", i), 32'(offset2), 32'd0);
    end
    wrap_en = 1'b0;

    // Exact press latency: first sample at edge k, move at edge k+17
    btn_left = 1'b1;
    hold(17);
    check("lat_before", 32'(offset), 32'd0);
    hold(1);
    check("lat_at", 32'(offset), 32'd1);
    check("lat_window", 32'(window), 32'h234);
    hold(40);
    check("lat_no_repeat", 32'(offset), 32'd1);
    btn_left = 1'b0;
    hold(30);
    check("lat_release", 32'(offset), 32'd1);
    press(1'b1, 1'b0);
    check("second_left", 32'(offset), 32'd2);

    // Bounce on the right button: short pulses are rejected
    for (int p = 5; p <= 15; p += 5) begin
      btn_right = 1'b1;
      hold(p);
      btn_right = 1'b0;
      hold(8);
      check($sformatf("bounce%0d", p), 32'(offset), 32'd2);
    end
    btn_right = 1'b1;
    hold(16);
    btn_right = 1'b0;
    hold(1);
    check("bounce_stable_before", 32'(offset), 32'd2);
    hold(1);
    check("bounce_stable_at", 32'(offset), 32'd1);
    hold(30);
    check("bounce_release", 32'(offset), 32'd1);

    // Both buttons together, then right re-pressed while left held
    btn_left  = 1'b1;
    btn_right = 1'b1;
    hold(30);
    check("both_held", 32'(offset), 32'd1);
    btn_right = 1'b0;
    hold(30);
    check("both_right_released", 32'(offset), 32'd1);
    btn_right = 1'b1;
    hold(20);
    check("right_while_left_held", 32'(offset), 32'd0);
    btn_left  = 1'b0;
    btn_right = 1'b0;
    hold(30);
    check("both_released", 32'(offset), 32'd0);

    // Reset mid-debounce with a button held through it
    press(1'b1, 1'b0);
    check("pre_reset_offset", 32'(offset), 32'd1);
    btn_left = 1'b1;
    hold(8);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_offset", 32'(offset), 32'd0);
    check("async_reset_window", 32'(window), 32'h345);
    model_reset();
    hold(3);
    rst_n = 1'b1;
    hold(16);
    check("held_after_reset_before", 32'(offset), 32'd0);
    hold(2);
    check("held_after_reset_after", 32'(offset), 32'd1);
    btn_left = 1'b0;
    hold(30);
    check("held_after_reset_release", 32'(offset), 32'd1);

    // Randomised run against the reference model, checked every cycle
    cmp_each = 1'b1;
    for (int it = 0; it < 120; it++) begin
      int sel;
      sel       = int'($urandom_range(0, 9));
      btn_left  = (sel < 4) || (sel == 8);
      btn_right = ((sel >= 4) && (sel < 8)) || (sel == 8);
      wrap_en   = $urandom_range(0, 1) == 1;
      bcd       = 20'($urandom);
      bcd2      = 16'($urandom);
      #1;
      compare_all("rnd_in");
      hold(int'($urandom_range(1, 40)));
    end
    cmp_each = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
